// File: rtl/mix_columns_engine.sv
// mix_columns_engine: iterative AES MixColumns / InvMixColumns on a 128-bit state.
// COLS_PER_CYCLE columns (1, 2 or 4) are transformed per clock, column 0 (MSBs) first.
// One block in flight, valid/ready on both sides, synchronous active-high reset.
// Optional feature: define MIXCOL_BYPASS_EN to add in_bypass, which passes the
// captured state through unchanged (AES final round) with identical timing.
module mix_columns_engine #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
`ifdef MIXCOL_BYPASS_EN
   input  logic         in_bypass,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int         BEATS     = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [1:0]  beat;
   logic        mode;
   logic [127:0] data_q;
   logic [31:0] col_res [COLS_PER_CYCLE];
`ifdef MIXCOL_BYPASS_EN
   logic        bypass;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One column through the forward or inverse matrix; the inverse multipliers
   // are built from the x2/x4/x8 chain so no generic multiplier is needed.
   function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
      logic [7:0] a [4];
      logic [7:0] m2 [4];
      logic [7:0] m3 [4];
      logic [7:0] m4 [4];
      logic [7:0] m8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [31:0] res;
      for (int r = 0; r < 4; r++) begin
         a[r]  = col[31-8*r -: 8];
         m2[r] = xtime(a[r]);
         m4[r] = xtime(m2[r]);
         m8[r] = xtime(m4[r]);
         m3[r] = m2[r] ^ a[r];
         m9[r] = m8[r] ^ a[r];
         mb[r] = m8[r] ^ m2[r] ^ a[r];
         md[r] = m8[r] ^ m4[r] ^ a[r];
         me[r] = m8[r] ^ m4[r] ^ m2[r];
      end
      if (inv) begin
         res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end else begin
         res[31:24] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
         res[23:16] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
         res[15:8]  = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
         res[7:0]   = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
      end
      return res;
   endfunction

   // Transform the columns selected by the current beat.
   always_comb begin
      // NOTE: every element gets a value on every pass, so no latch is inferred.
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         col_res[j] = '0;
      end
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
`ifdef MIXCOL_BYPASS_EN
         col_res[j] = bypass ? data_q[127-32*(int'(beat)*COLS_PER_CYCLE+j) -: 32]
                             : mix_column(data_q[127-32*(int'(beat)*COLS_PER_CYCLE+j) -: 32], mode);
`else
         col_res[j] = mix_column(data_q[127-32*(int'(beat)*COLS_PER_CYCLE+j) -: 32], mode);
`endif
      end
   end

   // Capture the block at accept; contents are never observed before capture.
   always_ff @(posedge clk) begin
      // NOTE: data_q carries no reset: it is always written before it is read.
      if (state == IDLE && in_valid) begin
         data_q <= in_data;
      end
   end

   // Control FSM with registered handshake outputs and the result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         beat      <= '0;
         mode      <= 1'b0;
`ifdef MIXCOL_BYPASS_EN
         bypass    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mode     <= in_inv;
`ifdef MIXCOL_BYPASS_EN
                  bypass   <= in_bypass;
`endif
                  beat     <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                  out_data[127-32*(int'(beat)*COLS_PER_CYCLE+j) -: 32] <= col_res[j];
               end
               if (beat == LAST_BEAT) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  beat <= beat + 2'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
